// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and frame-length
// helper, used by the transmitter today and by the receiver later.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Total bits on the line for one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned stop_bits,
                                             input bit parity_en);
    return 1 + DATA_BITS + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-source to UART transmitter handshake: data/enable in, line and status out.
interface uart_tx_if;

  logic [uart_pkg::DATA_BITS-1:0] in_tx_data;
  logic                           in_tx_en;
  logic                           out_serial;
  logic                           out_busy;
  logic                           out_done;

  modport master (
    output in_tx_data,
    output in_tx_en,
    input  out_serial,
    input  out_busy,
    input  out_done
  );

  modport slave (
    input  in_tx_data,
    input  in_tx_en,
    output out_serial,
    output out_busy,
    output out_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..cycles_per_bit-1 while enabled and pulses
// bit_tick on the last cycle of every bit period. Held at zero when disabled.
module uart_bit_timer #(
  parameter int unsigned cycles_per_bit = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(cycles_per_bit);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(cycles_per_bit - 1);

  logic [CNT_W-1:0] cnt;

  // Period counter: wraps on each bit boundary, never free-runs while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on the tx handshake and serialises it
// LSB-first as start, 8 data bits, optional even parity, then stop bit(s).
// Defining UART_TX_PARITY_EN inserts the even-parity bit (8E1); otherwise 8N1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned cycles_per_bit = 3,
  parameter int unsigned stop_bits      = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx
);

  uart_state_e          state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 stop_last;
  logic                 serial_next;
  logic                 timer_en;
  logic                 bit_tick;

  assign timer_en  = (state != IDLE);
  assign stop_last = (stop_cnt == 1'(stop_bits - 1));

  uart_bit_timer #(
    .cycles_per_bit(cycles_per_bit)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (timer_en),
    .bit_tick (bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Even parity of the accepted byte, captured once at accept time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (state == IDLE && tx.in_tx_en) begin
      parity_q <= ^tx.in_tx_data;
    end
  end
`endif

  // State, shift register and bit/stop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
    end
  end

  // Next-state: advance one frame element per bit_tick.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    case (state)
      IDLE: begin
        if (tx.in_tx_en) begin
          state_next    = START;
          shift_next    = tx.in_tx_data;
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_next   = {1'b0, shift[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (stop_last) state_next = IDLE;
          else           stop_cnt_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, taken from the next state so the
  // serial output can be registered without adding a cycle of latency.
  always_comb begin
    serial_next = 1'b1;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_next = parity_q;
`endif
      default: serial_next = 1'b1;
    endcase
  end

  // Registered line and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx.out_serial <= 1'b1;
      tx.out_busy   <= 1'b0;
    end else begin
      tx.out_serial <= serial_next;
      tx.out_busy   <= (state_next != IDLE);
    end
  end

  // Done marks the final cycle of the last stop bit; decoded from flops only.
  assign tx.out_done = (state == STOP) && stop_last && bit_tick;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits) share randomized
// stimulus; each is compared cycle by cycle against a waveform model built
// from the frame format (start, data LSB first, optional parity, stop bits).
module tb_uart_tx;

  localparam int unsigned CPB = 3;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_en   = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic serial;
    logic busy;
    logic done;
  } line_t;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned STOPS = g + 1;

    uart_tx_if bus();
    line_t     exp_q[$];

    assign bus.in_tx_data = tx_data;
    assign bus.in_tx_en   = tx_en;

    uart_tx #(
      .cycles_per_bit(CPB),
      .stop_bits     (STOPS)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .tx    (bus.slave)
    );

    // Expected per-cycle line contents for one whole frame after acceptance.
    function automatic void push_frame(input logic [7:0] d);
      logic  bits[$];
      line_t e;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^d);
`endif
      for (int s = 0; s < int'(STOPS); s++) bits.push_back(1'b1);
      for (int i = 0; i < bits.size(); i++) begin
        for (int c = 0; c < int'(CPB); c++) begin
          e.serial = bits[i];
          e.busy   = 1'b1;
          e.done   = (i == bits.size() - 1) && (c == int'(CPB) - 1);
          exp_q.push_back(e);
        end
      end
    endfunction

    // Model: one queue entry consumed per clock; accept only when idle.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (tx_en) push_frame(tx_data);
      end
    end

    // Compare outputs mid-cycle against the model.
    always @(negedge clk) begin
      line_t e;
      e = (exp_q.size() == 0) ? line_t'(3'b100) : exp_q[0];
      check($sformatf("L%0d.serial", g), 32'(bus.out_serial), 32'(e.serial));
      check($sformatf("L%0d.busy", g),   32'(bus.out_busy),   32'(e.busy));
      check($sformatf("L%0d.done", g),   32'(bus.out_done),   32'(e.done));
    end

    // Reset must take effect without waiting for a clock edge.
    always @(posedge reset) begin
      #1;
      check($sformatf("L%0d.rst_serial", g), 32'(bus.out_serial), 32'd1);
      check($sformatf("L%0d.rst_busy", g),   32'(bus.out_busy),   32'd0);
      check($sformatf("L%0d.rst_done", g),   32'(bus.out_done),   32'd0);
    end
  end

  task automatic send_pulse(input logic [7:0] d, input int gap);
    tx_data = d;
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (gap) begin
      tx_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    int hold;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Quiet line after reset.
    repeat (50) @(negedge clk);

    // Single frame with scrambled data afterwards.
    send_pulse(8'h48, 40);

    // Enable held high: back-to-back frames, data changed mid-frame.
    tx_data = 8'h55;
    tx_en   = 1'b1;
    repeat (5) @(negedge clk);
    tx_data = 8'hAA;
    repeat (70) @(negedge clk);
    tx_en = 1'b0;
    repeat (40) @(negedge clk);

    // All-zero and all-one bytes.
    send_pulse(8'h00, 40);
    send_pulse(8'hFF, 40);
    send_pulse(8'h07, 40);
    send_pulse(8'h03, 40);

    // Random bursts and gaps.
    repeat (25) begin
      tx_data = 8'($urandom);
      tx_en   = 1'b1;
      hold    = int'($urandom_range(1, 40));
      repeat (hold) begin
        @(negedge clk);
        tx_data = 8'($urandom);
      end
      tx_en = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (45) @(negedge clk);

    // Reset in the middle of data bit 4 of 0xFF.
    tx_data = 8'hFF;
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
